// File: rtl/dmem_unit.sv
// -----------------------------------------------------------------------------
// dmem_unit
//
// Byte-laned data memory behind the execute stage. One access is in flight at
// a time; each word phase takes LATENCY clock edges. Storage is four 8-bit
// banks (bank = byte address bits [1:0]). An access that straddles a word
// boundary is served in two phases (PHASE_A: word addr>>2, PHASE_B: next word,
// wrapping past the top) when DMEM_MISALIGN_EN is defined. Without that macro
// the address is forced to word alignment and `misaligned` flags the
// truncation alongside `done`.
//
// Configuration macro: DMEM_MISALIGN_EN (undefined by default).
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      clock edges per word phase (1..7)
//
// Ports:
//   clk           rising-edge clock
//   rst_b         asynchronous active-low reset
//   req           access start strobe, sampled only while idle
//   mem_write_en  1 = write, 0 = read (captured with req)
//   mem_addr      byte address (captured with req)
//   mem_data_in   write lanes; lane i targets byte mem_addr+i
//   mem_data_out  read lanes; lane i = byte mem_addr+i; held between accesses
//   busy          access in progress
//   done          one-cycle completion pulse
//   misaligned    pulses with done when an unaligned address was truncated
// -----------------------------------------------------------------------------
module dmem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req,
  input  logic            mem_write_en,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            busy,
  output logic            done,
  output logic            misaligned
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam int         BW       = AW + 2;  // byte-address width after aliasing
  localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PHASE_A = 2'd1;
  localparam logic [1:0] PHASE_B = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [BW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [0:3][7:0]   wdata_q, wdata_d;
  logic [0:3][7:0]   dout_q, dout_d;
  logic              done_q, done_d;
`ifndef DMEM_MISALIGN_EN
  logic              mis_pend_q, mis_pend_d;
  logic              mis_q, mis_d;
`endif

  // High address bits alias away; they are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:BW];

  // ---------------------------------------------------------------------------
  // Per-bank addressing. Bank k holds the byte of lane (k - offset) mod 4.
  // Banks at or above the offset belong to the base word (PHASE_A); banks below
  // it belong to the following word (PHASE_B).
  // ---------------------------------------------------------------------------
  logic [1:0]    offset;
  logic [AW-1:0] base_word;
  logic          bank_in_a [4];
  logic [1:0]    bank_lane [4];
  logic [AW-1:0] bank_widx [4];
  logic          wr_en     [4];
  logic [7:0]    rd_byte   [4];

  assign offset    = addr_q[1:0];
  assign base_word = addr_q[BW-1:2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bank_in_a[k] = (2'(k) >= offset);
      bank_lane[k] = 2'(k) - offset;
      bank_widx[k] = bank_in_a[k] ? base_word : base_word + AW'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] mem [DEPTH_WORDS];

    // NOTE: storage arrays are deliberately left out of reset; clearing them
    // would force flop-based storage and contents are undefined until written.
    always_ff @(posedge clk) begin
      if (wr_en[k]) mem[bank_widx[k]] <= wdata_q[bank_lane[k]];
    end

    assign rd_byte[k] = mem[bank_widx[k]];
  end

  // ---------------------------------------------------------------------------
  // Access FSM and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    for (int k = 0; k < 4; k++) wr_en[k] = 1'b0;
`ifndef DMEM_MISALIGN_EN
    mis_pend_d = mis_pend_q;
    mis_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mem_addr[BW-1:0];
          we_d    = mem_write_en;
          wdata_d = mem_data_in;
          cnt_d   = 3'd0;
          state_d = PHASE_A;
`ifndef DMEM_MISALIGN_EN
          // Truncate to word alignment; remember that we did so.
          addr_d[1:0] = 2'b00;
          mis_pend_d  = |mem_addr[1:0];
`endif
        end
      end

      PHASE_A, PHASE_B: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          // Final edge of the phase: serve only the banks owned by it.
          for (int k = 0; k < 4; k++) begin
            if (bank_in_a[k] == (state_q == PHASE_A)) begin
              wr_en[k] = we_q;
              if (!we_q) dout_d[bank_lane[k]] = rd_byte[k];
            end
          end
          // Writes present their own data on all lanes (write-through).
          if (we_q) dout_d = wdata_q;

          if ((state_q == PHASE_A) && (offset != 2'b00)) begin
            state_d = PHASE_B;
            cnt_d   = 3'd0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifndef DMEM_MISALIGN_EN
            mis_d   = mis_pend_q;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
`ifndef DMEM_MISALIGN_EN
      mis_pend_q <= 1'b0;
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
`ifndef DMEM_MISALIGN_EN
      mis_pend_q <= mis_pend_d;
      mis_q      <= mis_d;
`endif
    end
  end

  assign mem_data_out = dout_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
`ifdef DMEM_MISALIGN_EN
  assign misaligned   = 1'b0;
`else
  assign misaligned   = mis_q;
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_unit
//
// Scoreboarded bench for dmem_unit (DEPTH_WORDS=1024, LATENCY=2). The driver
// issues accesses, updates a byte-addressed reference memory and pushes the
// expected completion (data, valid-byte mask, misaligned flag, done edge). An
// independent monitor pops on every `done` pulse and compares. Covers the
// directed test-plan cases, back-to-back and ignored-while-busy requests,
// address aliasing/wrap, randomized traffic and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_dmem_unit;

  localparam int L     = 2;
  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;  // bytes in the memory

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            req = 1'b0;
  logic            mem_write_en = 1'b0;
  logic [31:0]     mem_addr = '0;
  logic [0:3][7:0] mem_data_in = '0;
  logic [0:3][7:0] mem_data_out;
  logic            busy, done, misaligned;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req          (req),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        mis;
    int          done_edge;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  logic [7:0] model_mem [NB];
  bit         known     [NB];

  int free_edge = 0;     // first edge at which a new req is accepted
  int cur_e0    = -100;  // accept edge of the access in flight
  int cur_lat   = 0;

  function automatic logic [11:0] eff_addr(input logic [31:0] a);
    logic [11:0] r;
    r = a[11:0];
`ifndef DMEM_MISALIGN_EN
    r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("read_data", mem_data_out & e.mask, e.data & e.mask);
        check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        check("done_edge", cyc, e.done_edge);
      end
    end else begin
      check("misaligned_idle", {31'd0, misaligned}, 32'd0);
    end
  end

  // ---------------- driver helpers (called at a negedge) ----------------
  task automatic busy_check();
    logic exp_busy;
    exp_busy = (cyc >= cur_e0) && (cyc < cur_e0 + cur_lat);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  // One idle cycle; while the DUT is busy, fire random requests it must ignore.
  task automatic tick();
    busy_check();
    req          = (cyc + 1 < free_edge) ? 1'($urandom % 2) : 1'b0;
    mem_write_en = 1'($urandom % 2);
    mem_addr     = $urandom;
    mem_data_in  = $urandom;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t        e;
    logic [11:0] a, b;
    int          lat;
    while (cyc + 1 < free_edge) tick();
    busy_check();
    a   = eff_addr(addr);
    lat = L;
`ifdef DMEM_MISALIGN_EN
    if (a[1:0] != 2'b00) lat = 2 * L;
`endif
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < 4; i++) begin
      b = a + 12'(i);
      if (we) begin
        model_mem[b] = data[31-8*i -: 8];
        known[b]     = 1'b1;
        e.data[31-8*i -: 8] = data[31-8*i -: 8];
        e.mask[31-8*i -: 8] = 8'hFF;
      end else begin
        e.data[31-8*i -: 8] = model_mem[b];
        e.mask[31-8*i -: 8] = known[b] ? 8'hFF : 8'h00;
      end
    end
`ifdef DMEM_MISALIGN_EN
    e.mis = 1'b0;
`else
    e.mis = (addr[1:0] != 2'b00);
`endif
    req          = 1'b1;
    mem_write_en = we;
    mem_addr     = addr;
    mem_data_in  = data;
    cur_e0       = cyc + 1;
    cur_lat      = lat;
    free_edge    = cur_e0 + lat + 1;
    e.done_edge  = cur_e0 + lat;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || cyc + 1 < free_edge) && t < 200) begin
      tick();
      t++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    case ($urandom % 4)
      0:       lo = 32'h100 + ($urandom % 32);
      1:       lo = 32'hFF0 + ($urandom % 16);
      2:       lo = $urandom % 16;
      default: lo = $urandom % NB;
    endcase
    return ($urandom & 32'hFFFF_F000) | lo;  // high bits alias
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          target, e0;
    logic [31:0] rd;
    logic [11:0] b;

    for (int i = 0; i < NB; i++) known[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", mem_data_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Directed test-plan accesses
    issue(1'b1, 32'h100, 32'h11223344);
    issue(1'b1, 32'h104, 32'h55667788);
    issue(1'b0, 32'h100, 32'h0);
    issue(1'b0, 32'h102, 32'h0);   // split {33,44,55,66} or truncated {11..44}
    issue(1'b1, 32'hFFE, 32'hA1B2C3D4);
    issue(1'b0, 32'hFFC, 32'h0);
    issue(1'b0, 32'h1000, 32'h0);  // aliases to word 0
    drain();

    // Randomized traffic with random gaps (gap 0 = req in the done cycle)
    repeat (200) begin
      repeat ($urandom % 3) tick();
      if ($urandom % 10 < 4) issue(1'b1, rand_addr(), $urandom);
      else                   issue(1'b0, rand_addr(), 32'h0);
    end
    drain();

    // Reset in the middle of a write to 0x201
    issue(1'b1, 32'h200, $urandom);
    issue(1'b1, 32'h204, $urandom);
    drain();
    rd           = $urandom;
    req          = 1'b1;
    mem_write_en = 1'b1;
    mem_addr     = 32'h201;
    mem_data_in  = rd;
    e0           = cyc + 1;
    @(negedge clk);
    req = 1'b0;
`ifdef DMEM_MISALIGN_EN
    target = e0 + L;      // PHASE_A committed, PHASE_B pending
`else
    target = e0 + L - 1;  // single phase not yet committed
`endif
    for (int t = 0; t < 20 && cyc < target; t++) @(negedge clk);
    check("busy_pre_reset", {31'd0, busy}, 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("rst_mid_dout", mem_data_out, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_mis", {31'd0, misaligned}, 32'd0);
`ifdef DMEM_MISALIGN_EN
    // Lanes 0..2 (bytes 0x201..0x203) were in PHASE_A and are committed.
    for (int i = 0; i < 3; i++) begin
      b = 12'h201 + 12'(i);
      model_mem[b] = rd[31-8*i -: 8];
      known[b]     = 1'b1;
    end
`endif
    @(negedge clk);
    rst_b     = 1'b1;
    cur_e0    = -100;
    free_edge = 0;
    @(negedge clk);
    issue(1'b0, 32'h200, 32'h0);
    issue(1'b0, 32'h204, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
